aes_host_loader: RTL and testbench

Host-side input stage for the AES-128 core. Accepts a 32-bit word-serial write bus and assembles the 128-bit seed key, the 2048-bit S-box table and 128-bit plaintext blocks. Drives the core's `key_in`/`key_in_vld`, `sbox_in`/`sbox_in_vld` and `data_in`/`data_in_vld` inputs, and throttles the host against the core's `data_accept`.

---
 rtl/aes_host_loader.sv | 151 +++++++++++++++
 tb/tb_aes_host_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_host_loader.sv
// Word-serial host write port that assembles the AES-128 key, S-box table and plaintext blocks.
// Define AES_LOADER_DATA_FIFO_EN to let the host build the next data block while one is pending.
module aes_host_loader #(
    parameter int WORD_W     = 32,
    parameter int KEY_WORDS  = 4,
    parameter int DATA_WORDS = 4,
    parameter int SBOX_WORDS = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_W-1:0]            host_wdata,
    input  logic [1:0]                   host_wsel,
    input  logic                         host_wvalid,
    output logic                         host_wready,
    output logic                         host_err,
    output logic [KEY_WORDS*WORD_W-1:0]  key_in,
    output logic                         key_in_vld,
    output logic [DATA_WORDS*WORD_W-1:0] data_in,
    output logic                         data_in_vld,
    output logic [SBOX_WORDS*WORD_W-1:0] sbox_in,
    output logic                         sbox_in_vld,
    input  logic                         data_accept
);

    localparam int KEY_W  = KEY_WORDS * WORD_W;
    localparam int DATA_W = DATA_WORDS * WORD_W;
    localparam int SBOX_W = SBOX_WORDS * WORD_W;
    // Holds up to N-1 words of the longest target; the completing word comes straight off the bus.
    localparam int ASM_W  = SBOX_W - WORD_W;

`ifdef AES_LOADER_DATA_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    localparam logic [1:0] SEL_KEY  = 2'b00;
    localparam logic [1:0] SEL_DATA = 2'b01;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        COLLECT   = 2'b01,
        DATA_HOLD = 2'b10
    } state_t;

    state_t            state, state_nx;
    logic [1:0]        cur_sel, sel_nx;
    logic [5:0]        cnt, cnt_nx;
    logic [ASM_W-1:0]  asm_sr;
    logic              xfer, accept, same_asm, completes;
    logic              shift_en, err_nx, key_done, data_done, sbox_done;

    function automatic int words_for(input logic [1:0] sel);
        case (sel)
            SEL_KEY:  return KEY_WORDS;
            SEL_DATA: return DATA_WORDS;
            default:  return SBOX_WORDS;
        endcase
    endfunction

    assign accept   = data_in_vld & data_accept;
    assign same_asm = (state == COLLECT) && (host_wsel == cur_sel);
    assign completes = same_asm ? (int'(cnt) == words_for(host_wsel) - 1)
                                : (words_for(host_wsel) == 1);

    // Only the word that would finish a data block stalls, and only while the slot stays occupied.
    assign host_wready = (state != DATA_HOLD) &&
                         !(FIFO_EN && host_wsel == SEL_DATA && completes &&
                           data_in_vld && !data_accept);
    assign xfer = host_wvalid & host_wready;

    // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        sel_nx    = cur_sel;
        cnt_nx    = cnt;
        shift_en  = 1'b0;
        err_nx    = 1'b0;
        key_done  = 1'b0;
        data_done = 1'b0;
        sbox_done = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (xfer) begin
                    if (host_wsel == SEL_RSVD) begin
                        err_nx = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                        err_nx   = (state == COLLECT) && (host_wsel != cur_sel);
                        sel_nx   = host_wsel;
                        if (completes) begin
                            cnt_nx   = '0;
                            state_nx = IDLE;
                            case (host_wsel)
                                SEL_KEY: key_done = 1'b1;
                                SEL_DATA: begin
                                    data_done = 1'b1;
                                    if (!FIFO_EN) state_nx = DATA_HOLD;
                                end
                                default: sbox_done = 1'b1;
                            endcase
                        end else begin
                            cnt_nx   = same_asm ? cnt + 6'd1 : 6'd1;
                            state_nx = COLLECT;
                        end
                    end
                end
            end
            DATA_HOLD: begin
                if (accept) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cur_sel     <= SEL_KEY;
            cnt         <= '0;
            asm_sr      <= '0;
            host_err    <= 1'b0;
            key_in      <= '0;
            key_in_vld  <= 1'b0;
            data_in     <= '0;
            data_in_vld <= 1'b0;
            sbox_in     <= '0;
            sbox_in_vld <= 1'b0;
        end else begin
            state       <= state_nx;
            cur_sel     <= sel_nx;
            cnt         <= cnt_nx;
            host_err    <= err_nx;
            key_in_vld  <= key_done;
            sbox_in_vld <= sbox_done;
            if (shift_en) asm_sr <= {asm_sr[ASM_W-WORD_W-1:0], host_wdata};
            if (key_done) key_in <= {asm_sr[KEY_W-WORD_W-1:0], host_wdata};
            if (sbox_done) sbox_in <= {asm_sr, host_wdata};
            // A completing block wins over release so a same-edge accept keeps the slot full.
            if (data_done) begin
                data_in     <= {asm_sr[DATA_W-WORD_W-1:0], host_wdata};
                data_in_vld <= 1'b1;
            end else if (accept) begin
                data_in_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_host_loader.sv
// Scoreboard bench for aes_host_loader: stimulus pushes expected strobes/blocks, a monitor pops them.
// Covers both builds; the back-to-back section runs only with AES_LOADER_DATA_FIFO_EN defined.
module tb_aes_host_loader;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   host_wdata = '0;
    logic [1:0]    host_wsel = '0;
    logic          host_wvalid = 1'b0;
    logic          data_accept = 1'b0;
    logic          host_wready, host_err;
    logic [127:0]  key_in, data_in;
    logic          key_in_vld, data_in_vld, sbox_in_vld;
    logic [2047:0] sbox_in;

    aes_host_loader dut (
        .clk         (clk),
        .reset       (reset),
        .host_wdata  (host_wdata),
        .host_wsel   (host_wsel),
        .host_wvalid (host_wvalid),
        .host_wready (host_wready),
        .host_err    (host_err),
        .key_in      (key_in),
        .key_in_vld  (key_in_vld),
        .data_in     (data_in),
        .data_in_vld (data_in_vld),
        .sbox_in     (sbox_in),
        .sbox_in_vld (sbox_in_vld),
        .data_accept (data_accept)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [127:0]  key_q[$];
    logic [127:0]  data_q[$];
    logic [2047:0] sbox_q[$];
    int            err_pending = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Offers one word and returns 1 time unit after the edge that transferred it.
    task automatic put(input logic [1:0] sel, input logic [31:0] w);
        int waited = 0;
        host_wsel   = sel;
        host_wdata  = w;
        host_wvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (host_wready) break;
            waited++;
            if (waited > 200) begin
                check("wready timeout", 128'(host_wready), 128'd1);
                break;
            end
        end
        next();
        host_wvalid = 1'b0;
    endtask

    task automatic put_block(input logic [1:0] sel, input logic [127:0] blk);
        for (int i = 0; i < 4; i++) begin
            logic [127:0] b;
            b = blk;
            put(sel, b[127-32*i -: 32]);
        end
    endtask

    function automatic logic [31:0] sbox_word(input int i);
        if (i == 0) return 32'h637C777B;
        return {8'(i), 8'(i + 64), 8'(i + 128), 8'(255 - i)};
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (key_in_vld) begin
                check("key strobe expected", 128'(key_q.size() != 0), 128'd1);
                if (key_q.size() != 0) check("key_in", key_in, key_q.pop_front());
            end
            if (sbox_in_vld) begin
                check("sbox strobe expected", 128'(sbox_q.size() != 0), 128'd1);
                if (sbox_q.size() != 0) begin
                    logic [2047:0] e;
                    e = sbox_q.pop_front();
                    check("sbox_in top word", 128'(sbox_in[2047:2016]), 128'(e[2047:2016]));
                    check("sbox_in full", 128'(sbox_in == e), 128'd1);
                end
            end
            if (data_in_vld && data_accept) begin
                check("data accept expected", 128'(data_q.size() != 0), 128'd1);
                if (data_q.size() != 0) check("data_in", data_in, data_q.pop_front());
            end
            if (host_err) begin
                check("host_err expected", 128'(err_pending > 0), 128'd1);
                if (err_pending > 0) err_pending--;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0]  k1, k2, k3, d0, d1, da, db;
        logic [2047:0] sb;
        k1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
        k2 = 128'h0102030405060708090A0B0C0D0E0F10;
        k3 = 128'hFEDCBA98765432100123456789ABCDEF;
        d0 = 128'h3243F6A8885A308D313198A2E0370734;
        d1 = 128'hAAAA1111BBBB2222CCCC3333DDDD4444;
        da = 128'h00112233445566778899AABBCCDDEEFF;
        db = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

        fork
            monitor();
        join_none

        // Reset state
        repeat (2) next();
        @(negedge clk);
        check("reset key_in", key_in, '0);
        check("reset data_in", data_in, '0);
        check("reset sbox_in zero", 128'(sbox_in == '0), 128'd1);
        check("reset vlds", {key_in_vld, data_in_vld, sbox_in_vld, host_err}, '0);
        next();
        reset = 1'b1;
        next();
        @(negedge clk);
        check("wready after reset", 128'(host_wready), 128'd1);
        next();

        // Key load, gapless
        key_q.push_back(k1);
        put_block(2'b00, k1);
        @(negedge clk);
        check("key_in_vld pulse", 128'(key_in_vld), 128'd1);
        @(negedge clk);
        check("key_in_vld one cycle", 128'(key_in_vld), 128'd0);
        check("key_in held", key_in, k1);
        next();

        // S-box load
        sb = '0;
        for (int i = 0; i < 64; i++) sb[2047-32*i -: 32] = sbox_word(i);
        sbox_q.push_back(sb);
        for (int i = 0; i < 64; i++) put(2'b10, sbox_word(i));
        @(negedge clk);
        check("sbox_in_vld pulse", 128'(sbox_in_vld), 128'd1);
        check("cnt cleared after sbox", 128'(dut.cnt), 128'd0);
        @(negedge clk);
        check("sbox_in_vld one cycle", 128'(sbox_in_vld), 128'd0);
        next();

        // Accept with nothing pending is ignored
        data_accept = 1'b1;
        @(negedge clk);
        check("idle accept vld", 128'(data_in_vld), 128'd0);
        next();
        data_accept = 1'b0;

        // Data hold for 10 cycles, then accept
        data_q.push_back(d0);
        put_block(2'b01, d0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("data_in_vld held", 128'(data_in_vld), 128'd1);
`ifndef AES_LOADER_DATA_FIFO_EN
            check("wready low in hold", 128'(host_wready), 128'd0);
`endif
            next();
        end
        data_accept = 1'b1;
        @(negedge clk);
        check("data_in_vld at accept", 128'(data_in_vld), 128'd1);
        next();
        data_accept = 1'b0;
        @(negedge clk);
        check("data_in_vld dropped", 128'(data_in_vld), 128'd0);
        check("wready after accept", 128'(host_wready), 128'd1);
        next();

`ifdef AES_LOADER_DATA_FIFO_EN
        // Back-to-back blocks: only the completing word stalls
        data_q.push_back(da);
        data_q.push_back(db);
        put_block(2'b01, da);
        for (int i = 0; i < 3; i++) begin
            host_wsel   = 2'b01;
            host_wdata  = db[127-32*i -: 32];
            host_wvalid = 1'b1;
            @(negedge clk);
            check("b2b no stall", 128'(host_wready), 128'd1);
            next();
        end
        host_wdata = db[31:0];
        @(negedge clk);
        check("b2b last word stalls", 128'(host_wready), 128'd0);
        next();
        @(negedge clk);
        check("b2b still stalled", 128'(host_wready), 128'd0);
        next();
        data_accept = 1'b1;
        @(negedge clk);
        check("b2b ready with accept", 128'(host_wready), 128'd1);
        next();
        host_wvalid = 1'b0;
        data_accept = 1'b0;
        @(negedge clk);
        check("b2b vld stays high", 128'(data_in_vld), 128'd1);
        check("b2b second block", data_in, db);
        next();
        data_accept = 1'b1;
        next();
        data_accept = 1'b0;
        @(negedge clk);
        check("b2b drained", 128'(data_in_vld), 128'd0);
        next();
`endif

        // Reserved sel mid-key: error pulse, assembly continues
        key_q.push_back(k2);
        put(2'b00, k2[127:96]);
        put(2'b00, k2[95:64]);
        err_pending++;
        put(2'b11, 32'hDEADBEEF);
        @(negedge clk);
        check("rsvd host_err", 128'(host_err), 128'd1);
        @(negedge clk);
        check("rsvd host_err one cycle", 128'(host_err), 128'd0);
        next();
        put(2'b00, k2[63:32]);
        put(2'b00, k2[31:0]);
        @(negedge clk);
        check("key after rsvd vld", 128'(key_in_vld), 128'd1);
        next();

        // Sel switch key->data after 2 words
        put(2'b00, 32'h5555AAAA);
        put(2'b00, 32'h6666BBBB);
        err_pending++;
        data_q.push_back(d1);
        put(2'b01, d1[127:96]);
        @(negedge clk);
        check("switch host_err", 128'(host_err), 128'd1);
        next();
        put(2'b01, d1[95:64]);
        put(2'b01, d1[63:32]);
        put(2'b01, d1[31:0]);
        @(negedge clk);
        check("switch data vld", 128'(data_in_vld), 128'd1);
        check("switch no key change", key_in, k2);
        next();
        data_accept = 1'b1;
        next();
        data_accept = 1'b0;

        // Reset after 37 S-box words
        for (int i = 0; i < 37; i++) put(2'b10, sbox_word(i));
        reset = 1'b0;
        #1;
        check("mid reset key_in", key_in, '0);
        check("mid reset data_in", data_in, '0);
        check("mid reset sbox_in zero", 128'(sbox_in == '0), 128'd1);
        check("mid reset flags", {key_in_vld, data_in_vld, sbox_in_vld, host_err}, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no strobe in reset", 128'(sbox_in_vld), 128'd0);
        end
        next();
        reset = 1'b1;
        @(negedge clk);
        check("wready after mid reset", 128'(host_wready), 128'd1);
        check("cnt after mid reset", 128'(dut.cnt), 128'd0);
        next();
        key_q.push_back(k3);
        put_block(2'b00, k3);
        @(negedge clk);
        check("key after reset vld", 128'(key_in_vld), 128'd1);
        repeat (3) next();

        check("key queue drained", 128'(key_q.size()), 128'd0);
        check("sbox queue drained", 128'(sbox_q.size()), 128'd0);
        check("data queue drained", 128'(data_q.size()), 128'd0);
        check("errors all seen", 128'(err_pending), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
